reg_file_mp: RTL
================

Name: reg_file_mp

Overview:
Parametrised multi-port register file for the 5-stage pipeline. It generalises the single-write, two-read register file in the following ways:
- configurable number of read ports;
- two prioritised write ports (ALU writeback, load writeback);
- optional hardwired zero register;
- optional write-to-read bypass;
- per-register pending scoreboard used by hazard detection in decode.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W entries (exactly, indices 0..2**ADDR_W-1)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0, ignores writes, never pending
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
raddr  input  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
rdata  output  NUM_RD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W]
rpend  output  NUM_RD  pending bit of the register addressed by each read port
w0_en  input  1  write port 0 enable (ALU writeback)
w0_addr  input  ADDR_W  write port 0 address
w0_data  input  DATA_W  write port 0 data
w1_en  input  1  write port 1 enable (load writeback)
w1_addr  input  ADDR_W  write port 1 address
w1_data  input  DATA_W  write port 1 data
iss_en  input  1  issue: mark destination register as pending
iss_addr  input  ADDR_W  destination register being issued
pend_cnt  output  ADDR_W+1  registered count of pending entries

Behaviour:
- Reset (rst high, asynchronous): all 2**ADDR_W entries cleared to 0, all pending bits cleared, pend_cnt = 0.
  - While rst is high, rdata = 0 and rpend = 0 on all ports.
  - Writes and issues are ignored while rst is high.
- Writes: sampled on the rising clk edge; the entry updates at that edge.
  - w0 and w1 to different addresses: both commit.
  - w0 and w1 to the same address in one cycle: w1 wins. The w0 data is discarded; its pending clear still applies.
- Reads: combinational, zero latency, from the array.
  - With BYPASS=1: if raddr[i] matches an enabled write address in the same cycle, rdata[i] returns that write data (w1 over w0) instead of the stale array value.
  - With BYPASS=0: the array value is returned; new data is visible the cycle after the write.
- ZERO_REG=1:
  - Address 0 always reads 0, including under bypass.
  - Writes to address 0 are dropped.
  - iss_addr = 0 sets nothing; rpend for address 0 is always 0.
- Scoreboard (one pending bit per entry):
  - A pending bit is set at the clk edge when iss_en is high and iss_addr selects the entry.
  - A pending bit is cleared at the clk edge by any enabled write (w0 or w1) to the entry.
  - Set and clear of the same entry in the same cycle: set wins (a new producer has been issued).
  - Issue to an entry that is already pending: the bit stays 1; no counting of multiple producers.
  - rpend[i] is combinational from the current pending bits. With BYPASS=1, a clear by a same-cycle write is also reflected (rpend=0), unless an issue to the same entry occurs in that cycle.
- pend_cnt:
  - Registered population count of the pending bits, updated at the same edge as the bits.
  - Range 0..2**ADDR_W. Never wraps: width ADDR_W+1 holds the full depth.
- Out-of-range addressing is impossible: every address value indexes a real entry.
- Reset mid-operation: clears the array and the scoreboard immediately, with no clk edge needed. Normal operation resumes on the first clk edge after rst deasserts.

Test Plan:
- Reset: preload r5=0xDEADBEEF, assert rst between clk edges -> rdata for raddr=5 reads 0 immediately, rpend=0, pend_cnt=0.
- Dual write conflict: w0(7,0x11111111) and w1(7,0x22222222) in the same cycle -> next cycle r7=0x22222222; pending for r7 cleared.
- Bypass: BYPASS=1, w0(3,0xA5A5A5A5) with raddr0=3 in the same cycle -> rdata0=0xA5A5A5A5 in that cycle. Repeat with BYPASS=0 -> old value in that cycle, new value the next cycle.
- Zero register: w1(0,0xFFFFFFFF) plus iss(0), then read r0 -> rdata=0, rpend=0, pend_cnt unchanged.
- Scoreboard: iss r4 -> rpend for r4=1 and pend_cnt=1 next cycle. Then iss r4 together with w0(4,x) in the same cycle -> r4 stays pending, pend_cnt=1. Then w1(4,y) alone -> pending cleared, pend_cnt=0.
- Full scoreboard: ZERO_REG=0, issue all 32 entries over 32 cycles -> pend_cnt=32 with no wrap. Write all 32 back -> pend_cnt=0.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with pending scoreboard.
//   Two prioritised write ports (w1 beats w0 on the same address), NUM_RD
//   combinational read ports, an optional hardwired zero entry, optional
//   same-cycle write-to-read bypass and one pending bit per entry.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   raddr_i         packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata_o         packed read data, port i at [i*DATA_W +: DATA_W] (comb)
//   rpend_o         pending bit of each addressed entry (comb)
//   w0_*_i          write port 0 (ALU writeback)
//   w1_*_i          write port 1 (load writeback, higher priority)
//   iss_en_i/addr_i issue: mark destination entry pending
//   pend_cnt_o      registered number of pending entries
module reg_file_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr_i,
  output logic [NUM_RD*DATA_W-1:0]   rdata_o,
  output logic [NUM_RD-1:0]          rpend_o,
  input  logic                       w0_en_i,
  input  logic [ADDR_W-1:0]          w0_addr_i,
  input  logic [DATA_W-1:0]          w0_data_i,
  input  logic                       w1_en_i,
  input  logic [ADDR_W-1:0]          w1_addr_i,
  input  logic [DATA_W-1:0]          w1_data_i,
  input  logic                       iss_en_i,
  input  logic [ADDR_W-1:0]          iss_addr_i,
  output logic [ADDR_W:0]            pend_cnt_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic [CNT_W-1:0]  pend_cnt_q;
  logic [CNT_W-1:0]  pend_cnt_d;

  // Effective write/issue strobes; the zero entry swallows both.
  logic w0_ok, w1_ok, iss_ok;
  assign w0_ok  = w0_en_i  && !((ZERO_REG != 0) && (w0_addr_i  == '0));
  assign w1_ok  = w1_en_i  && !((ZERO_REG != 0) && (w1_addr_i  == '0));
  assign iss_ok = iss_en_i && !((ZERO_REG != 0) && (iss_addr_i == '0));

  // Array next state: w1 applied last so it wins an address conflict.
  always_comb begin
    mem_d = mem_q;
    if (w0_ok) mem_d[w0_addr_i] = w0_data_i;
    if (w1_ok) mem_d[w1_addr_i] = w1_data_i;
  end

  // Scoreboard next state: clears first, then issue so set wins.
  always_comb begin
    pend_d = pend_q;
    if (w0_ok)  pend_d[w0_addr_i]  = 1'b0;
    if (w1_ok)  pend_d[w1_addr_i]  = 1'b0;
    if (iss_ok) pend_d[iss_addr_i] = 1'b1;
  end

  // Population count of the next scoreboard, registered alongside it.
  always_comb begin
    pend_cnt_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pend_cnt_d = pend_cnt_d + CNT_W'(pend_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt_o = pend_cnt_q;

  // Read ports: array value, optional bypass, zero entry, reset gating.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rp;
    logic              hit0, hit1, hit_iss;

    assign ra      = raddr_i[g*ADDR_W +: ADDR_W];
    assign hit0    = w0_en_i  && (w0_addr_i  == ra);
    assign hit1    = w1_en_i  && (w1_addr_i  == ra);
    assign hit_iss = iss_en_i && (iss_addr_i == ra);

    always_comb begin
      rd = mem_q[ra];
      rp = pend_q[ra];
      if (BYPASS != 0) begin
        if (hit1)      rd = w1_data_i;
        else if (hit0) rd = w0_data_i;
        // A same-cycle write retires the producer unless a new one issues.
        if ((hit0 || hit1) && !hit_iss) rp = 1'b0;
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
        rp = 1'b0;
      end
      // Bypassed write data must not leak out while reset is held.
      if (rst) begin
        rd = '0;
        rp = 1'b0;
      end
    end

    assign rdata_o[g*DATA_W +: DATA_W] = rd;
    assign rpend_o[g]                  = rp;
  end

endmodule
